// File: rtl/add_scheduler.sv
// add_scheduler: round-robin two-requester adder sharing one HALF-width slice over two cycles.
module add_scheduler #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id,
    output logic             busy
);
    localparam int HALF = WIDTH / 2;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_sum_q, res_sum_d;
    logic [HALF-1:0]  lo_q, lo_d, sx, sy, ss;
    logic             id_q, id_d, last_id_q, last_id_d, carry_q, carry_d;
    logic             res_cout_q, res_cout_d, res_id_q, res_id_d;
    logic             grant, accept, sc, cin;

    always_ff @(posedge clk or posedge reset)
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? LO : IDLE;
            LO:      state_d = HI;
            HI:      state_d = DONE;
            default: state_d = res_ready ? IDLE : DONE;
        endcase
    end

    always_comb begin
        req0_ready = !reset && state_q == IDLE && req0_valid && !grant;
        req1_ready = !reset && state_q == IDLE && req1_valid && grant;
        res_valid  = state_q == DONE;
        busy       = state_q != IDLE;
    end

    // Contention goes to whoever was not served last; a lone requester always wins.
    always_comb begin
        grant  = (req0_valid && req1_valid) ? ~last_id_q : req1_valid;
        accept = state_q == IDLE && (req0_valid || req1_valid);
        sx     = state_q == HI ? a_q[WIDTH-1:HALF] : a_q[HALF-1:0];
        sy     = state_q == HI ? b_q[WIDTH-1:HALF] : b_q[HALF-1:0];
        cin    = state_q == HI ? carry_q : 1'b0;
        {sc, ss} = {1'b0, sx} + {1'b0, sy} + (HALF + 1)'(cin);
    end

    always_comb begin
        a_d        = accept ? (grant ? req1_a : req0_a) : a_q;
        b_d        = accept ? (grant ? req1_b : req0_b) : b_q;
        id_d       = accept ? grant : id_q;
        last_id_d  = accept ? grant : last_id_q;
        lo_d       = state_q == LO ? ss : lo_q;
        carry_d    = state_q == LO ? sc : carry_q;
        res_sum_d  = state_q == HI ? {ss, lo_q} : res_sum_q;
        res_cout_d = state_q == HI ? sc : res_cout_q;
        res_id_d   = state_q == HI ? id_q : res_id_q;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            last_id_q  <= 1'b1;
            lo_q       <= '0;
            carry_q    <= 1'b0;
            res_sum_q  <= '0;
            res_cout_q <= 1'b0;
            res_id_q   <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            id_q       <= id_d;
            last_id_q  <= last_id_d;
            lo_q       <= lo_d;
            carry_q    <= carry_d;
            res_sum_q  <= res_sum_d;
            res_cout_q <= res_cout_d;
            res_id_q   <= res_id_d;
        end

    assign res_sum  = res_sum_q;
    assign res_cout = res_cout_q;
    assign res_id   = res_id_q;
endmodule

// File: tb/tb_add_scheduler.sv
// tb_add_scheduler: timeline model of the scheduler checked every cycle, plus literal result checks.
module tb_add_scheduler;
    logic        clk = 0, reset = 0;
    logic        req0_valid = 0, req1_valid = 0, res_ready = 0;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic        req0_ready, req1_ready, res_valid, res_cout, res_id, busy;
    logic [31:0] res_sum;

    add_scheduler #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_cout(res_cout), .res_id(res_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    int acc_cyc[$], res_cyc[$];
    bit acc_id[$], res_idq[$];
    logic [32:0] res_val[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: an operation is in flight for a number of cycles after its accept.
    bit          m_pend = 0, m_last = 1, m_opid = 0, m_cout = 0, m_id = 0, win;
    int          m_age = 0;
    logic [32:0] m_op = 0;
    logic [31:0] m_sum = 0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (reset) begin
            m_pend = 0; m_age = 0; m_last = 1; m_sum = 0; m_cout = 0; m_id = 0;
        end
        win = (req0_valid && req1_valid) ? ~m_last : req1_valid;
        check("busy", busy, m_pend);
        check("res_valid", res_valid, m_pend && m_age >= 2);
        check("req0_ready", req0_ready, !reset && !m_pend && req0_valid && !win);
        check("req1_ready", req1_ready, !reset && !m_pend && req1_valid && win);
        check("res_sum", res_sum, m_sum);
        check("res_cout", res_cout, m_cout);
        check("res_id", res_id, m_id);
        if (!reset) begin
            if (!m_pend) begin
                if (req0_valid || req1_valid) begin
                    m_pend = 1; m_age = 0; m_opid = win; m_last = win;
                    m_op = win ? {1'b0, req1_a} + {1'b0, req1_b} : {1'b0, req0_a} + {1'b0, req0_b};
                    acc_cyc.push_back(cyc); acc_id.push_back(win);
                end
            end else if (m_age < 2) begin
                m_age++;
                if (m_age == 2) begin
                    {m_cout, m_sum} = m_op;
                    m_id = m_opid;
                end
            end else if (res_ready) begin
                m_pend = 0;
                res_val.push_back({m_cout, m_sum}); res_idq.push_back(m_id); res_cyc.push_back(cyc);
            end
        end
    end

    task automatic issue(input bit n, input logic [31:0] a, input logic [31:0] b, input bit keep);
        bit got = 0;
        if (n) begin req1_a = a; req1_b = b; req1_valid = 1; end
        else   begin req0_a = a; req0_b = b; req0_valid = 1; end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = n ? req1_ready : req0_ready;
        end
        if (!got) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        if (!keep) begin
            if (n) req1_valid = 0; else req0_valid = 0;
        end
    endtask

    task automatic wait_idle();
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = !busy;
        end
        if (!got) check("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    int base, nres;
    bit got;
    logic [31:0] sa[3] = '{32'h80000000, 32'h7FFFFFFF, 32'h0000FFFF};
    logic [31:0] sb[3] = '{32'h80000000, 32'h00000001, 32'h0000FFFF};
    logic [32:0] se[3] = '{33'h100000000, 33'h080000000, 33'h00001FFFE};

    initial begin
        reset = 1; res_ready = 1;
        #1;
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_res_sum", res_sum, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 0;

        issue(0, 32'h0000FFFF, 32'h00000001, 0);
        wait_idle();
        check("t1_sum", res_val[0], 33'h000010000);
        check("t1_id", res_idq[0], 0);
        check("t1_latency", res_cyc[0] - acc_cyc[0], 3);

        issue(1, 32'hFFFFFFFF, 32'h00000001, 0);
        wait_idle();
        check("t2_sum", res_val[1], 33'h100000000);
        check("t2_id", res_idq[1], 1);

        base = acc_cyc.size();
        nres = res_val.size();
        req0_a = 32'h00000001; req0_b = 32'h00000002;
        req1_a = 32'hFFFF0000; req1_b = 32'h00010000;
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 60 && acc_cyc.size() < base + 4; i++) @(negedge clk);
        check("t3_accepts", acc_cyc.size() - base, 4);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            check("t3_grant", acc_id[base + i], i % 2);
            check("t3_res_id", res_idq[nres + i], i % 2);
            check("t3_sum", res_val[nres + i], (i % 2) ? 33'h100000000 : 33'h000000003);
            if (i > 0) check("t3_spacing", acc_cyc[base + i] - acc_cyc[base + i - 1], 4);
        end

        res_ready = 0;
        issue(0, 32'h12345678, 32'h11111111, 0);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = res_valid;
        end
        check("t4_valid_seen", got, 1);
        @(posedge clk); #1;
        req1_a = 32'h00000005; req1_b = 32'h00000006; req1_valid = 1;
        repeat (5) begin
            @(negedge clk);
            check("t4_hold_sum", res_sum, 32'h23456789);
            check("t4_hold_valid", res_valid, 1);
            check("t4_rdy", {req0_ready, req1_ready}, 0);
        end
        @(posedge clk); #1;
        res_ready = 1;
        @(negedge clk);
        @(negedge clk);
        check("t4_idle_after", busy, 0);
        @(posedge clk); #1;
        req1_valid = 0;
        wait_idle();

        issue(1, 32'h0F0F0F0F, 32'h01010101, 0);
        @(posedge clk); #1;
        reset = 1;
        #1;
        check("t5_res_valid", res_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_res_sum", res_sum, 0);
        check("t5_res_id", res_id, 0);
        nres = res_val.size();
        @(posedge clk); #1;
        reset = 0;
        req0_a = 32'h00000010; req0_b = 32'h00000020; req0_valid = 1;
        req1_a = 32'h00000030; req1_b = 32'h00000040; req1_valid = 1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = req0_ready || req1_ready;
            if (got) check("t5_first_grant", {req0_ready, req1_ready}, 2'b10);
        end
        if (!got) check("t5_grant_timeout", 0, 1);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        wait_idle();
        check("t5_results", res_val.size() - nres, 1);
        check("t5_sum", res_val[nres], 33'h000000030);

        base = acc_cyc.size();
        nres = res_val.size();
        for (int i = 0; i < 3; i++) issue(1, sa[i], sb[i], i < 2);
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            check("t6_sum", res_val[nres + i], se[i]);
            check("t6_id", res_idq[nres + i], 1);
            if (i > 0) check("t6_spacing", acc_cyc[base + i] - acc_cyc[base + i - 1], 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
